// File: rtl/frame_word_assembler_pkg.sv
// rtl/frame_word_assembler_pkg.sv - shared FSM states, word width and FIFO entry layout
package frame_word_assembler_pkg;

   localparam int MAX_WORD_W = 32;

   typedef enum logic [0:0] {
      WAIT_SYNC = 1'b0,
      ASSEMBLE  = 1'b1
   } fsm_state_t;

   typedef struct packed {
      logic                  eof;
      logic                  sof;
      logic [MAX_WORD_W-1:0] data;
   } fifo_entry_t;

   // Mask keeping the low (bits_minus1 + 1) bits of a word.
   function automatic logic [MAX_WORD_W-1:0] word_mask(input logic [4:0] bits_minus1);
      word_mask = {MAX_WORD_W{1'b1}} >> (5'd31 - bits_minus1);
   endfunction

endpackage

// File: rtl/frame_word_assembler_word_fifo.sv
// rtl/frame_word_assembler_word_fifo.sv - show-ahead word buffer with count-based full/empty
module word_fifo
   import frame_word_assembler_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  fifo_entry_t pushEntry,
   input  logic        pop,
   output logic        accepted,
   output logic        notEmpty,
   output fifo_entry_t head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fifo_entry_t   mem [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [CW-1:0] count;
   logic          full;
   logic          doPop;

   assign full     = (count == CW'(DEPTH));
   assign notEmpty = (count != '0);
   assign doPop    = pop && notEmpty;
   // A full buffer still takes a word when the head leaves in the same cycle.
   assign accepted = push && (!full || doPop);
   assign head     = notEmpty ? mem[rdPtr] : '0;

   always_ff @(posedge clk) begin
      if (accepted) begin
         mem[wrPtr] <= pushEntry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (accepted) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({accepted, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/frame_word_assembler.sv
// rtl/frame_word_assembler.sv - packs framer bits into payload words with SOF/EOF tags
module frame_word_assembler
   import frame_word_assembler_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clkEn,
   input  logic        framedBit,
   input  logic        framesync,
   input  logic        framesyncPulse,
   input  logic [4:0]  bitsPerWord,
   input  logic [15:0] wordsPerFrame,
   input  logic        wordReady,
   output logic        wordValid,
   output logic [31:0] wordData,
   output logic        wordSof,
   output logic        wordEof,
   output logic        overflow,
   input  logic        clearOverflow,
   output logic [15:0] frameCount
);

   fsm_state_t  state;
   logic [4:0]  bitCnt;
   logic [15:0] wordCnt;
   logic [31:0] shiftReg;
   logic        bitStep;
   logic        push;
   logic        accepted;
   fifo_entry_t pushEntry;
   fifo_entry_t head;

   // A resync pulse wins over the bit that arrives with it.
   assign bitStep        = (state == ASSEMBLE) && clkEn && framesync && !framesyncPulse;
   assign push           = bitStep && (bitCnt == '0);
   assign pushEntry.eof  = (wordCnt == wordsPerFrame);
   assign pushEntry.sof  = (wordCnt == '0);
   assign pushEntry.data = {shiftReg[30:0], framedBit} & word_mask(bitsPerWord);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= WAIT_SYNC;
         bitCnt   <= '0;
         wordCnt  <= '0;
         shiftReg <= '0;
      end else if (!framesync) begin
         state   <= WAIT_SYNC;
         bitCnt  <= '0;
         wordCnt <= '0;
      end else if (clkEn) begin
         case (state)
            WAIT_SYNC: begin
               if (framesyncPulse) begin
                  state   <= ASSEMBLE;
                  bitCnt  <= bitsPerWord;
                  wordCnt <= '0;
               end
            end
            ASSEMBLE: begin
               if (framesyncPulse) begin
                  bitCnt  <= bitsPerWord;
                  wordCnt <= '0;
               end else begin
                  shiftReg <= {shiftReg[30:0], framedBit};
                  if (bitCnt == '0) begin
                     bitCnt <= bitsPerWord;
                     if (wordCnt == wordsPerFrame) begin
                        state   <= WAIT_SYNC;
                        bitCnt  <= '0;
                        wordCnt <= '0;
                     end else begin
                        wordCnt <= wordCnt + 1'b1;
                     end
                  end else begin
                     bitCnt <= bitCnt - 1'b1;
                  end
               end
            end
            default: state <= WAIT_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow   <= 1'b0;
         frameCount <= '0;
      end else begin
         if (clearOverflow) begin
            overflow <= 1'b0;
         end else if (push && !accepted) begin
            overflow <= 1'b1;
         end
         if (accepted && pushEntry.eof) begin
            frameCount <= frameCount + 1'b1;
         end
      end
   end

   word_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_word_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pushEntry(pushEntry),
      .pop      (wordReady),
      .accepted (accepted),
      .notEmpty (wordValid),
      .head     (head)
   );

   assign wordData = head.data;
   assign wordSof  = head.sof;
   assign wordEof  = head.eof;

endmodule

// File: tb/tb_frame_word_assembler.sv
// tb/tb_frame_word_assembler.sv - directed bench with a bit-list reference model
module tb_frame_word_assembler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        clkEn;
   logic        framedBit;
   logic        framesync;
   logic        framesyncPulse;
   logic [4:0]  bitsPerWord;
   logic [15:0] wordsPerFrame;
   logic        wordReady;
   logic        wordValid;
   logic [31:0] wordData;
   logic        wordSof;
   logic        wordEof;
   logic        overflow;
   logic        clearOverflow;
   logic [15:0] frameCount;

   int          total  = 0;
   int          passed = 0;
   logic        chk_en = 1'b0;

   logic [33:0] mq[$];
   int          mbits[$];
   bit          mactive;
   int          midx;
   logic        mover;
   logic [15:0] mfc;
   logic [33:0] got[$];

   always #5 clk = ~clk;

   frame_word_assembler #(
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .clkEn         (clkEn),
      .framedBit     (framedBit),
      .framesync     (framesync),
      .framesyncPulse(framesyncPulse),
      .bitsPerWord   (bitsPerWord),
      .wordsPerFrame (wordsPerFrame),
      .wordReady     (wordReady),
      .wordValid     (wordValid),
      .wordData      (wordData),
      .wordSof       (wordSof),
      .wordEof       (wordEof),
      .overflow      (overflow),
      .clearOverflow (clearOverflow),
      .frameCount    (frameCount)
   );

   function automatic logic [33:0] ent(input logic eof, input logic sof, input logic [31:0] d);
      ent = {eof, sof, d};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference: collect bits in a list, form the word arithmetically once enough have arrived.
   always @(posedge clk) begin
      logic [31:0] v;
      logic [33:0] e;
      if (reset) begin
         mq.delete();
         mbits.delete();
         mactive = 0;
         midx    = 0;
         mover   = 1'b0;
         mfc     = '0;
      end else begin
         if (mq.size() > 0 && wordReady) void'(mq.pop_front());
         if (!framesync) begin
            mactive = 0;
            mbits.delete();
         end else if (clkEn) begin
            if (!mactive) begin
               if (framesyncPulse) begin
                  mactive = 1;
                  midx    = 0;
                  mbits.delete();
               end
            end else if (framesyncPulse) begin
               midx = 0;
               mbits.delete();
            end else begin
               mbits.push_back(int'(framedBit));
               if (mbits.size() == int'(bitsPerWord) + 1) begin
                  v = 0;
                  foreach (mbits[i]) v = v * 2 + 32'(mbits[i]);
                  e = {(midx == int'(wordsPerFrame)), (midx == 0), v};
                  if (mq.size() < DEPTH) begin
                     mq.push_back(e);
                     if (e[33]) mfc++;
                  end else begin
                     mover = 1'b1;
                  end
                  mbits.delete();
                  if (midx == int'(wordsPerFrame)) begin
                     mactive = 0;
                     midx    = 0;
                  end else begin
                     midx++;
                  end
               end
            end
         end
         if (clearOverflow) mover = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wordValid", wordValid, mq.size() != 0);
         if (mq.size() != 0) chk("head", {wordEof, wordSof, wordData}, mq[0]);
         chk("overflow", overflow, mover);
         chk("frameCount", frameCount, mfc);
         if (wordValid && wordReady) got.push_back({wordEof, wordSof, wordData});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      clkEn = 1'b1; framedBit = b;
      tick();
      clkEn = 1'b0; framedBit = ~b;
      tick();
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic sync_pulse();
      framesync = 1'b1; framesyncPulse = 1'b1; clkEn = 1'b1;
      tick();
      framesyncPulse = 1'b0; clkEn = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; clkEn = 1'b0; framedBit = 1'b0; framesync = 1'b0;
      framesyncPulse = 1'b0; bitsPerWord = 5'd7; wordsPerFrame = 16'd2;
      wordReady = 1'b1; clearOverflow = 1'b0;
      idle(2);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_valid", wordValid, 0);
      chk("rst_data", wordData, 0);
      chk("rst_sof", wordSof, 0);
      chk("rst_eof", wordEof, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frameCount", frameCount, 0);

      // Three-byte frame
      got.delete();
      sync_pulse();
      send_bits(32'hA5, 8); send_bits(32'h3C, 8); send_bits(32'h0F, 8);
      idle(6);
      chk("s1_count", got.size(), 3);
      chk("s1_w0", got[0], ent(0, 1, 32'hA5));
      chk("s1_w1", got[1], ent(0, 0, 32'h3C));
      chk("s1_w2", got[2], ent(1, 0, 32'h0F));
      chk("s1_fc", frameCount, 1);

      // Single 32-bit word frames
      got.delete();
      bitsPerWord = 5'd31; wordsPerFrame = 16'd0;
      sync_pulse(); send_bits(32'hDEADBEEF, 32); idle(4);
      chk("s2_fc1", frameCount, 2);
      sync_pulse(); send_bits(32'h12345678, 32); idle(4);
      chk("s2_w0", got[0], ent(1, 1, 32'hDEADBEEF));
      chk("s2_w1", got[1], ent(1, 1, 32'h12345678));
      chk("s2_fc2", frameCount, 3);

      // Lock lost after 4 bits of word 1
      got.delete();
      bitsPerWord = 5'd7; wordsPerFrame = 16'd2;
      sync_pulse(); send_bits(32'h11, 8); send_bits(32'h2, 4);
      framesync = 1'b0; tick(); framesync = 1'b1;
      send_bits(32'hFF, 8); idle(4);
      chk("s3_count", got.size(), 1);
      chk("s3_w0", got[0], ent(0, 1, 32'h11));
      chk("s3_fc", frameCount, 3);
      sync_pulse(); send_bits(32'h44, 8); send_bits(32'h55, 8); send_bits(32'h66, 8); idle(4);
      chk("s3_count2", got.size(), 4);
      chk("s3_w1", got[1], ent(0, 1, 32'h44));
      chk("s3_w3", got[3], ent(1, 0, 32'h66));

      // Resync mid-word 1
      got.delete();
      sync_pulse(); send_bits(32'h77, 8); send_bits(32'h5, 3);
      sync_pulse(); send_bits(32'h88, 8); send_bits(32'h99, 8); send_bits(32'hAA, 8); idle(4);
      chk("s4_count", got.size(), 4);
      chk("s4_w1", got[1], ent(0, 1, 32'h88));
      chk("s4_w3", got[3], ent(1, 0, 32'hAA));
      chk("s4_fc", frameCount, 5);

      // Overflow with a stalled consumer
      got.delete();
      wordReady = 1'b0; wordsPerFrame = 16'd5;
      sync_pulse();
      for (int w = 1; w <= 6; w++) send_bits(32'(w), 8);
      chk("s5_ovf", overflow, 1);
      chk("s5_head", {wordEof, wordSof, wordData}, ent(0, 1, 32'h01));
      chk("s5_fc", frameCount, 5);
      sync_pulse();
      send_bits(32'h07 >> 1, 7);
      clearOverflow = 1'b1; clkEn = 1'b1; framedBit = 1'b1;
      tick();
      clearOverflow = 1'b0; clkEn = 1'b0;
      chk("s5_clear_dominates", overflow, 0);
      tick();
      send_bits(32'h08 >> 1, 7);
      wordReady = 1'b1; clkEn = 1'b1; framedBit = 1'b0;
      tick();
      wordReady = 1'b0; clkEn = 1'b0;
      chk("s5_pop_push_ovf", overflow, 0);
      tick();
      wordReady = 1'b1; idle(8);
      chk("s5_count", got.size(), 5);
      chk("s5_w0", got[0], ent(0, 1, 32'h01));
      chk("s5_w3", got[3], ent(0, 0, 32'h04));
      chk("s5_w4", got[4], ent(0, 0, 32'h08));
      framesync = 1'b0; tick(); framesync = 1'b1;

      // Reset mid-frame with three words buffered
      wordReady = 1'b0;
      sync_pulse(); send_bits(32'h31, 8); send_bits(32'h32, 8); send_bits(32'h33, 8); send_bits(32'h3, 4);
      chk("s6_pre_fc", frameCount, 5);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("s6_valid", wordValid, 0);
      chk("s6_fc", frameCount, 0);
      got.delete();
      wordReady = 1'b1;
      send_bits(32'hA5, 8); idle(4);
      chk("s6_silent", got.size(), 0);
      wordsPerFrame = 16'd0;
      sync_pulse(); send_bits(32'hC3, 8); idle(4);
      chk("s6_count", got.size(), 1);
      chk("s6_w0", got[0], ent(1, 1, 32'hC3));
      chk("s6_fc2", frameCount, 1);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
